// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store front end for a byte-enabled 1-cycle-read RAM
// One request at a time: decode and check at accept, drive RAM for one cycle, extend load data, respond.
module load_store_unit #(
  parameter int ADDR_W      = 8,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [31:0]       ram_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;

  logic        accept;
  logic        bad_f3;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Request decode: error classification and store lane placement.
  always_comb begin
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    st_be      = 4'b0000;
    st_wdata   = 32'd0;
    case (req_funct3)
      3'b000: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        misaligned = req_addr[0];
        st_be      = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        misaligned = |req_addr[1:0];
        st_be      = 4'b1111;
        st_wdata   = req_wdata;
      end
      3'b100: bad_f3 = req_we;
      3'b101: begin
        bad_f3     = req_we;
        misaligned = req_addr[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    out_of_range = CHECK_RANGE && ((req_addr >> (ADDR_W + 2)) != 32'd0);
    req_err      = bad_f3 || misaligned || out_of_range;
  end

  always_comb begin
    ld_byte = ram_q[{lat_off, 3'b000} +: 8];
    ld_half = lat_off[1] ? ram_q[31:16] : ram_q[15:0];
    case (lat_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = ram_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_off   <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= 4'd0;
      ram_wdata <= 32'd0;
      ram_waddr <= '0;
      ram_raddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we  <= req_we;
            lat_f3  <= req_funct3;
            lat_off <= req_addr[1:0];
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              // RAM ports are driven on entry so ACCESS presents them for exactly one cycle.
              state     <= ACCESS;
              ram_waddr <= req_addr[ADDR_W+1:2];
              ram_raddr <= req_addr[ADDR_W+1:2];
              ram_we    <= req_we;
              ram_be    <= req_we ? st_be : 4'd0;
              ram_wdata <= req_we ? st_wdata : 32'd0;
            end
          end
        end
        ACCESS: begin
          ram_we    <= 1'b0;
          ram_be    <= 4'd0;
          ram_wdata <= 32'd0;
          if (lat_we) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= ld_data;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
